// File: rtl/neuron_pkg.sv
// Shared widths and state encoding for the neuron source and display blocks.
package neuron_pkg;

  localparam int unsigned POT_W   = 10;
  localparam int unsigned SPIKE_W = 16;

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_FIRE      = 2'd1,
    ST_REFRACT   = 2'd2
  } state_t;

endpackage

// File: rtl/step_timer.sv
// Time-step prescaler: counts 0..c_STEP_CYCLES-1 and strobes on the terminal count.
module step_timer #(
  parameter int unsigned c_STEP_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  output logic o_Time_Step
);

  localparam int unsigned W = $clog2(c_STEP_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count       <= '0;
      o_Time_Step <= 1'b0;
    end else begin
      if (count == W'(c_STEP_CYCLES - 1)) count <= '0;
      else                                count <= count + W'(1);
      // Registered strobe is decoded one count early so it is high while count == last.
      o_Time_Step <= (count == W'(c_STEP_CYCLES - 2));
    end
  end

endmodule

// File: rtl/spike_generator.sv
// Leaky integrate-and-fire spike source: integrates per time step, fires a
// multi-step pulse at threshold, then sits out a refractory period.
module spike_generator
  import neuron_pkg::*;
#(
  parameter int unsigned c_STEP_CYCLES   = 250000,
  parameter int unsigned c_THRESHOLD     = 350,
  parameter int unsigned c_LEAK          = 2,
  parameter int unsigned c_WEIGHT        = 60,
  parameter int unsigned c_BASE_CURRENT  = 10,
  parameter int unsigned c_V_MAX         = 1023,
  parameter int unsigned c_PULSE_STEPS   = 2,
  parameter int unsigned c_REFRACT_STEPS = 20
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Stimulus,
  input  logic               i_Bias_En,
  output logic               o_Action_Potential,
  output logic [POT_W-1:0]   o_Potential,
  output logic [1:0]         o_State,
  output logic [SPIKE_W-1:0] o_Spike_Count,
  output logic               o_Time_Step
);

  localparam int unsigned SUM_W  = 12;
  localparam int unsigned STEP_W = 16;

  state_t               state;
  logic [POT_W-1:0]     v;
  logic [SPIKE_W-1:0]   spikes;
  logic [STEP_W-1:0]    steps_left;
  logic                 ap;
  logic                 stim_d;
  logic                 pending;
  logic                 time_step;
  logic                 rise;
  logic                 hit;
  logic [SUM_W-1:0]     leaked;
  logic [SUM_W-1:0]     sum;
  logic [POT_W-1:0]     sat;

  step_timer #(.c_STEP_CYCLES(c_STEP_CYCLES)) u_step_timer (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .o_Time_Step (time_step)
  );

  // An edge arriving on the step cycle itself is folded into that step.
  always_comb begin
    rise   = i_Stimulus & ~stim_d;
    hit    = pending | rise;
    leaked = '0;
    if (v > POT_W'(c_LEAK)) leaked = {2'b00, v - POT_W'(c_LEAK)};
    sum = leaked + (hit ? SUM_W'(c_WEIGHT) : '0)
                 + (i_Bias_En ? SUM_W'(c_BASE_CURRENT) : '0);
    sat = (sum > SUM_W'(c_V_MAX)) ? POT_W'(c_V_MAX) : sum[POT_W-1:0];
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= ST_INTEGRATE;
      v          <= '0;
      spikes     <= '0;
      steps_left <= '0;
      ap         <= 1'b0;
      stim_d     <= 1'b0;
      pending    <= 1'b0;
    end else begin
      stim_d <= i_Stimulus;
      if (time_step)  pending <= 1'b0;
      else if (rise)  pending <= 1'b1;

      if (time_step) begin
        case (state)
          ST_INTEGRATE: begin
            if ({2'b00, sat} >= SUM_W'(c_THRESHOLD)) begin
              state      <= ST_FIRE;
              v          <= POT_W'(c_V_MAX);
              ap         <= 1'b1;
              spikes     <= spikes + SPIKE_W'(1);
              steps_left <= STEP_W'(c_PULSE_STEPS - 1);
            end else begin
              v <= sat;
            end
          end
          ST_FIRE: begin
            if (steps_left != '0) begin
              steps_left <= steps_left - STEP_W'(1);
            end else begin
              ap <= 1'b0;
              v  <= '0;
              if (c_REFRACT_STEPS > 0) begin
                state      <= ST_REFRACT;
                steps_left <= STEP_W'(c_REFRACT_STEPS - 1);
              end else begin
                state <= ST_INTEGRATE;
              end
            end
          end
          ST_REFRACT: begin
            if (steps_left != '0) steps_left <= steps_left - STEP_W'(1);
            else                  state      <= ST_INTEGRATE;
          end
          default: state <= ST_INTEGRATE;
        endcase
      end
    end
  end

  assign o_Action_Potential = ap;
  assign o_Potential        = v;
  assign o_State            = state;
  assign o_Spike_Count      = spikes;
  assign o_Time_Step        = time_step;

endmodule

// File: tb/tb_spike_generator.sv
// Bench for spike_generator: directed scenarios plus random stimulus, with two
// instances (default refractory and zero refractory) checked every cycle
// against a step-level reference model.
module tb_spike_generator;

  localparam int STEP   = 4;
  localparam int THR    = 350;
  localparam int LEAK   = 2;
  localparam int WEIGHT = 60;
  localparam int BASE   = 10;
  localparam int VMAX   = 1023;
  localparam int PULSE  = 2;

  typedef struct {
    int v; int st; int left; int spikes;
    bit ap; bit pend; bit prev;
  } model_t;

  logic clk, rst_l, stim, bias;
  logic a_ap, a_ts, b_ap, b_ts;
  logic [9:0]  a_pot, b_pot;
  logic [1:0]  a_state, b_state;
  logic [15:0] a_cnt, b_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ap_cycles;
  int pcnt;
  bit track = 0;
  model_t ma, mb;

  spike_generator #(.c_STEP_CYCLES(STEP)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Stimulus(stim), .i_Bias_En(bias),
    .o_Action_Potential(a_ap), .o_Potential(a_pot), .o_State(a_state),
    .o_Spike_Count(a_cnt), .o_Time_Step(a_ts)
  );

  spike_generator #(.c_STEP_CYCLES(STEP), .c_REFRACT_STEPS(0)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Stimulus(stim), .i_Bias_En(bias),
    .o_Action_Potential(b_ap), .o_Potential(b_pot), .o_State(b_state),
    .o_Spike_Count(b_cnt), .o_Time_Step(b_ts)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock of neuron behaviour; state changes only when 'step' is set.
  function automatic model_t model_cycle(model_t m, bit s, bit b, bit step, int refract);
    bit rise;
    int sum;
    rise   = s && !m.prev;
    m.prev = s;
    if (!step) begin
      if (rise) m.pend = 1;
      return m;
    end
    sum = 0;
    if (m.st == 0) begin
      sum = (m.v > LEAK) ? m.v - LEAK : 0;
      if (m.pend || rise) sum += WEIGHT;
      if (b) sum += BASE;
      if (sum > VMAX) sum = VMAX;
      if (sum >= THR) begin
        m.st = 1; m.v = VMAX; m.ap = 1; m.left = PULSE;
        m.spikes = (m.spikes + 1) % 65536;
      end else begin
        m.v = sum;
      end
    end else if (m.st == 1) begin
      m.left--;
      if (m.left == 0) begin
        m.ap = 0; m.v = 0;
        if (refract > 0) begin m.st = 2; m.left = refract; end
        else m.st = 0;
      end
    end else begin
      m.left--;
      if (m.left == 0) m.st = 0;
    end
    m.pend = 0;
    return m;
  endfunction

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ma   = '{default: 0};
      mb   = '{default: 0};
      pcnt = 0;
    end else begin
      ma   = model_cycle(ma, stim, bias, pcnt == STEP - 1, 20);
      mb   = model_cycle(mb, stim, bias, pcnt == STEP - 1, 0);
      pcnt = (pcnt + 1) % STEP;
    end
  end

  always @(negedge clk) begin
    if (track && rst_l === 1'b1) begin
      check("a_ap",    a_ap,    ma.ap);
      check("a_pot",   a_pot,   ma.v);
      check("a_state", a_state, ma.st);
      check("a_cnt",   a_cnt,   ma.spikes);
      check("a_ts",    a_ts,    pcnt == STEP - 1);
      check("b_ap",    b_ap,    mb.ap);
      check("b_pot",   b_pot,   mb.v);
      check("b_state", b_state, mb.st);
      check("b_cnt",   b_cnt,   mb.spikes);
      check("b_ts",    b_ts,    pcnt == STEP - 1);
    end
  end

  // Drives one time step; pat[c] is the stimulus level for cycle c of the step.
  task automatic run_step(input logic [3:0] pat);
    for (int c = 0; c < STEP; c++) begin
      stim = pat[c];
      @(negedge clk);
      if (a_ap) ap_cycles++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 0;
    @(negedge clk);
    rst_l = 1;
  endtask

  initial begin
    int n;
    stim = 0; bias = 0; rst_l = 0; ap_cycles = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ap",    a_ap, 0);
    check("rst_pot",   a_pot, 0);
    check("rst_state", a_state, 0);
    check("rst_cnt",   a_cnt, 0);
    check("rst_ts",    a_ts, 0);
    rst_l = 1;
    track = 1;

    for (int k = 1; k <= 5; k++) begin
      run_step(4'b0001);
      check("climb_pot", a_pot, 60 * k - 2 * (k - 1));
    end
    ap_cycles = 0;
    run_step(4'b0001);
    check("fire_state", a_state, 1);
    check("fire_pot",   a_pot, 1023);
    check("fire_cnt",   a_cnt, 1);
    check("fire_ap",    a_ap, 1);

    run_step(4'b0001);
    check("fire2_state", a_state, 1);
    run_step(4'b0001);
    check("refr_entry", a_state, 2);
    check("refr_pot0",  a_pot, 0);
    for (int k = 1; k <= 20; k++) begin
      run_step(4'b0001);
      check("refr_state", a_state, (k < 20) ? 2 : 0);
      check("refr_pot",   a_pot, 0);
    end
    check("ap_width", ap_cycles, PULSE * STEP);

    run_step(4'b0001);
    check("leak_start", a_pot, 60);
    for (int k = 1; k <= 33; k++) begin
      run_step(4'b0000);
      check("leak_pot", a_pot, (60 - 2 * k > 0) ? 60 - 2 * k : 0);
    end

    run_step(4'b0101);
    check("merge_pot", a_pot, 60);
    run_step(4'b1000);
    check("edge_on_step", a_pot, 118);
    run_step(4'b0000);
    check("no_double", a_pot, 116);

    do_reset();
    bias = 1;
    for (int k = 1; k <= 43; k++) begin
      run_step(4'b0000);
      if (k == 1) check("bias_first", b_pot, 10);
    end
    check("bias_pre_fire", b_pot, 346);
    check("bias_pre_state", b_state, 0);
    run_step(4'b0000);
    check("bias_fire_state", b_state, 1);
    check("bias_fire_pot",   b_pot, 1023);
    check("bias_fire_cnt",   b_cnt, 1);
    run_step(4'b0000);
    check("bias_hold", b_state, 1);
    run_step(4'b0000);
    check("norefr_state", b_state, 0);
    check("norefr_pot",   b_pot, 0);
    check("norefr_ap",    b_ap, 0);

    n = 0;
    while (mb.st != 1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("refire_seen", mb.st, 1);
    #2 rst_l = 0;
    #1;
    check("async_ap",  b_ap, 0);
    check("async_pot", b_pot, 0);
    check("async_cnt", b_cnt, 0);
    @(negedge clk);
    rst_l = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_ts && n < 10);
    check("ts_after_release", n, 3);

    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) bias = 1'($urandom_range(0, 1));
      stim = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end

    track = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
